// File: rtl/class2_pkg.sv
// class2_pkg
// Shared definitions for the class2 feature loader slice.
//   FEAT_W          : width of the feature vector consumed by class2_tree1
//   loader_state_t  : loader FSM states (LOAD, EVAL, HOLD)
//   calc_nchunk     : number of CHUNK_W-wide chunks needed to cover FEAT_W bits
package class2_pkg;

    localparam int FEAT_W = 51;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

    // Ceiling division: a partial final chunk still needs its own transfer.
    function automatic int calc_nchunk(input int feat_w, input int chunk_w);
        return (feat_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/class2_tree1.sv
// class2_tree1
// Combinational decision-tree classifier over a 51-bit feature vector.
// The currently trained tree resolves every leaf to class 0, so the output
// is constant; the feature input is still reduced so the port stays connected
// and the interface is ready for a retrained tree.
// Ports:
//   i : feature vector (51 bits)
//   o : predicted class (1 bit)
module class2_tree1 (
    input  logic [50:0] i,
    output logic        o
);

    logic unused_features;

    // Every leaf of the trained tree votes class 0.
    assign unused_features = ^i;
    assign o               = 1'b0;

endmodule

// File: rtl/class2_feature_loader.sv
// class2_feature_loader
// Streaming front end for class2_tree1. Assembles a FEAT_W-bit feature vector
// from an LSB-first chunk stream, holds it stable into the tree, registers the
// classification and returns it together with a malformed-frame flag.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : chunk input stream
//   m_valid/m_ready/m_class/m_err : result output stream
//   busy          : high unless idle in LOAD with no chunk of a frame taken
// Optional build macro CLASS2_LOADER_STATS_EN adds saturating 16-bit
// counters stat_frames, stat_errs and stat_ones, updated on each result
// handshake.
module class2_feature_loader #(
    parameter int FEAT_W  = class2_pkg::FEAT_W,
    parameter int CHUNK_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHUNK_W-1:0] s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_class,
    output logic               m_err,
    output logic               busy
`ifdef CLASS2_LOADER_STATS_EN
    ,
    output logic [15:0]        stat_frames,
    output logic [15:0]        stat_errs,
    output logic [15:0]        stat_ones
`endif
);

    import class2_pkg::*;

    localparam int NCHUNK = calc_nchunk(FEAT_W, CHUNK_W);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [CNT_W-1:0]  cnt;
    logic              err;
    logic              drain;
    logic [FEAT_W-1:0] feat;
    logic              tree_o;
    logic              accept;

    class2_tree1 u_tree (
        .i (feat),
        .o (tree_o)
    );

    // Next-state and handshake outputs. s_ready, m_valid and busy depend only
    // on registered state so they never combinationally follow s_valid.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                busy    = (cnt != '0);
                accept  = s_valid;
                if (s_valid && s_last) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                state_next = HOLD;
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State register and datapath. A frame that runs past NCHUNK chunks sets
    // err and enters drain mode, where chunks are swallowed without touching
    // feat until s_last arrives. cnt is held during drain so busy stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            cnt     <= '0;
            err     <= 1'b0;
            drain   <= 1'b0;
            feat    <= '0;
            m_class <= 1'b0;
            m_err   <= 1'b0;
`ifdef CLASS2_LOADER_STATS_EN
            stat_frames <= '0;
            stat_errs   <= '0;
            stat_ones   <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (accept) begin
                        // Chunk cnt lands at bits cnt*CHUNK_W upward; bits past
                        // FEAT_W of the final chunk simply have no destination.
                        if (!drain) begin
                            for (int b = 0; b < FEAT_W; b++) begin
                                if (CNT_W'(b / CHUNK_W) == cnt) begin
                                    feat[b] <= s_data[b % CHUNK_W];
                                end
                            end
                        end
                        if (s_last) begin
                            cnt   <= '0;
                            drain <= 1'b0;
                            if (!drain && (cnt != LAST_CNT)) begin
                                err <= 1'b1;
                            end
                        end else if (!drain) begin
                            if (cnt == LAST_CNT) begin
                                err   <= 1'b1;
                                drain <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                EVAL: begin
                    m_class <= tree_o & ~err;
                    m_err   <= err;
                end
                HOLD: begin
                    if (m_ready) begin
                        err <= 1'b0;
`ifdef CLASS2_LOADER_STATS_EN
                        if (m_err) begin
                            if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
                        end else begin
                            if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
                        end
                        if (m_class && (stat_ones != 16'hFFFF)) begin
                            stat_ones <= stat_ones + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_class2_feature_loader.sv
// tb_class2_feature_loader
// Self-checking bench for class2_feature_loader. A frame-level model turns
// every accepted chunk stream into an expected result (feature vector,
// error flag, class) and a cycle-level expectation of the handshake signals.
module tb_class2_feature_loader;

    localparam int FW = 51;
    localparam int CW = 8;
    localparam int NC = (FW + CW - 1) / CW;
    // The trained tree answers class 0 for every feature vector.
    localparam bit TREE_CLASS = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [CW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic          m_class;
    logic          m_err;
    logic          busy;
`ifdef CLASS2_LOADER_STATS_EN
    logic [15:0]   stat_frames;
    logic [15:0]   stat_errs;
    logic [15:0]   stat_ones;
`endif

    class2_feature_loader #(.FEAT_W(FW), .CHUNK_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_class (m_class),
        .m_err   (m_err),
        .busy    (busy)
`ifdef CLASS2_LOADER_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_errs   (stat_errs),
        .stat_ones   (stat_ones)
`endif
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        logic [FW-1:0] feat;
        bit            err;
        bit            cls;
    } result_t;

    result_t          exp_q[$];
    bit               check_en     = 1'b0;
    bit               in_result    = 1'b0;
    int               last_cyc     = 0;
    int               frame_chunks = 0;
    int               cyc          = 0;
    logic [FW-1:0]    feat_model   = '0;
    logic [NC*CW-1:0] frame_buf    = '0;
    bit               hold_prev    = 1'b0;
    bit               prev_cls, prev_err;
    bit               last_hs_err  = 1'b0;
    int               results_seen = 0;
    int               good_seen    = 0;
    int               bad_seen     = 0;
    int               ones_seen    = 0;
    int               mr_mode      = 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        n_compared++;
        n_failed++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // Per-cycle compare against the frame-level model. Accepts and result
    // handshakes are taken from the sampled bus; expected results are formed
    // at frame end from how many chunks the frame actually carried.
    always @(negedge clk) begin
        result_t r;
        bit      ferr;
        if (check_en) begin
            checkOutput("s_ready", s_ready, !in_result);
            checkOutput("m_valid", m_valid, in_result && (cyc - last_cyc >= 2));
            checkOutput("busy", busy, in_result || (frame_chunks != 0));
            if (hold_prev) begin
                checkOutput("m_class_stable", m_class, prev_cls);
                checkOutput("m_err_stable", m_err, prev_err);
            end
            hold_prev = m_valid && !m_ready;
            prev_cls  = m_class;
            prev_err  = m_err;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_failed++;
                    $display("[TB] FAIL unexpected_result: got a result, expected none");
                end else begin
                    r = exp_q.pop_front();
                    checkOutput("m_class", m_class, r.cls);
                    checkOutput("m_err", m_err, r.err);
                    checkOutput("feat", dut.feat, r.feat);
                    last_hs_err = r.err;
                    results_seen++;
                    if (r.err) bad_seen++; else good_seen++;
                    if (r.cls) ones_seen++;
                end
                in_result = 1'b0;
            end
            if (s_valid && s_ready) begin
                if (frame_chunks < NC) frame_buf[frame_chunks*CW +: CW] = s_data;
                frame_chunks++;
                if (s_last) begin
                    ferr       = (frame_chunks != NC);
                    feat_model = frame_buf[FW-1:0];
                    r.feat     = feat_model;
                    r.err      = ferr;
                    r.cls      = ferr ? 1'b0 : TREE_CLASS;
                    exp_q.push_back(r);
                    frame_buf    = {{(NC*CW-FW){1'b0}}, feat_model};
                    frame_chunks = 0;
                    in_result    = 1'b1;
                    last_cyc     = cyc;
                end
            end
        end
        if (rst) begin
            in_result    = 1'b0;
            frame_chunks = 0;
            feat_model   = '0;
            frame_buf    = '0;
            hold_prev    = 1'b0;
            exp_q.delete();
        end
        cyc++;
    end

    // Result consumer: always ready, never ready, or random.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                1:       m_ready = 1'b1;
                2:       m_ready = 1'b0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendChunk(input logic [CW-1:0] d, input bit last, input bit gaps);
        int waited = 0;
        bit ok;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (1) begin
            @(negedge clk);
            ok = s_ready;
            tick();
            if (ok) break;
            waited++;
            if (waited > 200) begin
                failNow("chunk_accept_timeout");
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = CW'($urandom);
    endtask

    // Table data is (k+1)*0x11 so chunk 7 and 8 read 0x88 and 0x99.
    task automatic applyStimulus(input int len, input bit gaps, input bit use_table);
        logic [CW-1:0] d;
        for (int k = 0; k < len; k++) begin
            d = use_table ? CW'((k + 1) * 17) : CW'($urandom);
            sendChunk(d, k == len - 1, gaps);
        end
    endtask

    task automatic waitResult();
        int w = 0;
        while ((in_result || exp_q.size() != 0) && w < 300) begin
            tick();
            w++;
        end
        if (w >= 300) failNow("result_timeout");
    endtask

    initial begin
        int seen_before;
        int w;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        tick();
        check_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_m_class", m_class, 0);
        checkOutput("reset_m_err", m_err, 0);
        checkOutput("reset_feat", dut.feat, 0);
        checkOutput("reset_busy", busy, 0);

        // Good frame with known data.
        $display("[TB] good frame");
        applyStimulus(NC, 1'b0, 1'b1);
        waitResult();
        checkOutput("good_feat_literal", dut.feat, 64'h0007_6655_4433_2211);
        checkOutput("model_feat_literal", feat_model, 64'h0007_6655_4433_2211);
        checkOutput("good_err_literal", last_hs_err, 0);

        // Short frame.
        $display("[TB] short frame");
        applyStimulus(3, 1'b0, 1'b1);
        waitResult();
        checkOutput("short_err_literal", last_hs_err, 1);
        checkOutput("short_cnt", dut.cnt, 0);
        checkOutput("short_s_ready", s_ready, 1);

        // Long frame, then a good one.
        $display("[TB] long frame");
        seen_before = results_seen;
        applyStimulus(NC + 2, 1'b0, 1'b1);
        waitResult();
        checkOutput("long_single_result", results_seen - seen_before, 1);
        checkOutput("long_err_literal", last_hs_err, 1);
        checkOutput("long_feat_literal", dut.feat, 64'h0007_6655_4433_2211);
        applyStimulus(NC, 1'b1, 1'b0);
        waitResult();
        checkOutput("after_long_err_literal", last_hs_err, 0);

        // Backpressure for 10 cycles in HOLD.
        $display("[TB] backpressure");
        mr_mode = 2;
        tick();
        applyStimulus(NC, 1'b0, 1'b0);
        w = 0;
        while (!m_valid && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) failNow("m_valid_rise_timeout");
        repeat (10) begin
            checkOutput("bp_s_ready", s_ready, 0);
            tick();
        end
        mr_mode = 1;
        waitResult();

        // Reset in the middle of a frame.
        $display("[TB] mid-frame reset");
        for (int k = 0; k < 5; k++) sendChunk(CW'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_m_class", m_class, 0);
        checkOutput("rst_m_err", m_err, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_feat", dut.feat, 0);
        checkOutput("rst_cnt", dut.cnt, 0);
        applyStimulus(NC, 1'b0, 1'b1);
        waitResult();
        checkOutput("rst_good_feat_literal", dut.feat, 64'h0007_6655_4433_2211);

        // Random soak with random lengths, gaps and consumer stalls.
        $display("[TB] random soak");
        mr_mode = 0;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NC + 3) : NC;
            applyStimulus(len, 1'b1, 1'b0);
        end
        mr_mode = 1;
        waitResult();

`ifdef CLASS2_LOADER_STATS_EN
        checkOutput("stat_frames", stat_frames, good_seen);
        checkOutput("stat_errs", stat_errs, bad_seen);
        checkOutput("stat_ones", stat_ones, ones_seen);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
